// File: rtl/rc4_ksa_engine_if.sv
// rtl/rc4_ksa_engine_if.sv - control handshake and S-box RAM port bundle for rc4_ksa_engine
// key_len exists only when RC4_KSA_KEYLEN_EN is defined.
interface rc4_ksa_engine_if #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] key;
`ifdef RC4_KSA_KEYLEN_EN
  localparam int KEY_LEN_W = $clog2(KEY_BYTES + 1);
  logic [KEY_LEN_W-1:0]   key_len;
`endif
  logic                   busy;
  logic                   done;
  logic [DATA_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_wren;
  logic [DATA_W-1:0]      mem_rdata;

`ifdef RC4_KSA_KEYLEN_EN
  modport master (
    input  start, key, key_len, mem_rdata,
    output busy, done, mem_addr, mem_wdata, mem_wren
  );
  modport slave (
    output start, key, key_len, mem_rdata,
    input  busy, done, mem_addr, mem_wdata, mem_wren
  );
`else
  modport master (
    input  start, key, mem_rdata,
    output busy, done, mem_addr, mem_wdata, mem_wren
  );
  modport slave (
    output start, key, mem_rdata,
    input  busy, done, mem_addr, mem_wdata, mem_wren
  );
`endif
endinterface

// File: rtl/rc4_ksa_engine.sv
// rtl/rc4_ksa_engine.sv - RC4 key scheduling (S-box init + shuffle) as sole master of one sync S-box RAM
// Optional feature macro: RC4_KSA_KEYLEN_EN (runtime key_len input; otherwise L = KEY_BYTES).
module rc4_ksa_engine #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  rc4_ksa_engine_if.master    ksa
);
  localparam int KEY_W  = 8 * KEY_BYTES;
  localparam int KIDX_W = $clog2(KEY_BYTES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RD_I, S_LD_I, S_RD_J, S_LD_J, S_WR_I, S_WR_J, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_i;
  logic [DATA_W-1:0]   r_j;
  logic [DATA_W-1:0]   r_si;
  logic [DATA_W-1:0]   r_sj;
  logic [KEY_W-1:0]    r_key;
  logic [KIDX_W-1:0]   r_kidx;
  logic [KIDX_W-1:0]   r_kmax;
  logic [KIDX_W-1:0]   w_kmax_start;
  logic [7:0]          w_key_byte;
  logic [DATA_W-1:0]   w_kb;
  logic                w_last_i;

  assign w_last_i = (r_i == {DATA_W{1'b1}});

  // r_kmax holds L-1 so the key-byte counter wraps without any divide
  always_comb begin
`ifdef RC4_KSA_KEYLEN_EN
    if ((ksa.key_len == '0) || (ksa.key_len > KIDX_W'(KEY_BYTES)))
      w_kmax_start = KIDX_W'(KEY_BYTES - 1);
    else
      w_kmax_start = ksa.key_len - KIDX_W'(1);
`else
    w_kmax_start = KIDX_W'(KEY_BYTES - 1);
`endif
  end

  always_comb begin
    w_key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (r_kidx == KIDX_W'(b))
        w_key_byte = r_key[KEY_W-1-8*b -: 8];
    end
  end

  assign w_kb = DATA_W'(w_key_byte);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (ksa.start) w_next_state = S_INIT;
      S_INIT:  if (w_last_i)  w_next_state = S_RD_I;
      S_RD_I:  w_next_state = S_LD_I;
      S_LD_I:  w_next_state = S_RD_J;
      S_RD_J:  w_next_state = S_LD_J;
      S_LD_J:  w_next_state = S_WR_I;
      S_WR_I:  w_next_state = S_WR_J;
      S_WR_J:  w_next_state = w_last_i ? S_DONE : S_RD_I;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // When i==j both writes land on one address; the second carries si==sj, so S is unchanged
  always_comb begin
    ksa.busy      = 1'b0;
    ksa.done      = 1'b0;
    ksa.mem_addr  = '0;
    ksa.mem_wdata = '0;
    ksa.mem_wren  = 1'b0;
    case (r_state)
      S_INIT: begin
        ksa.busy      = 1'b1;
        ksa.mem_addr  = r_i;
        ksa.mem_wdata = r_i;
        ksa.mem_wren  = 1'b1;
      end
      S_RD_I: begin
        ksa.busy     = 1'b1;
        ksa.mem_addr = r_i;
      end
      S_LD_I, S_LD_J: ksa.busy = 1'b1;
      S_RD_J: begin
        ksa.busy     = 1'b1;
        ksa.mem_addr = r_j;
      end
      S_WR_I: begin
        ksa.busy      = 1'b1;
        ksa.mem_addr  = r_i;
        ksa.mem_wdata = r_sj;
        ksa.mem_wren  = 1'b1;
      end
      S_WR_J: begin
        ksa.busy      = 1'b1;
        ksa.mem_addr  = r_j;
        ksa.mem_wdata = r_si;
        ksa.mem_wren  = 1'b1;
      end
      S_DONE:  ksa.done = 1'b1;
      default: ksa.busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_i    <= '0;
      r_j    <= '0;
      r_si   <= '0;
      r_sj   <= '0;
      r_key  <= '0;
      r_kidx <= '0;
      r_kmax <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ksa.start) begin
            r_key  <= ksa.key;
            r_kmax <= w_kmax_start;
            r_kidx <= '0;
            r_i    <= '0;
            r_j    <= '0;
          end
        end
        S_INIT: r_i <= r_i + DATA_W'(1);
        S_LD_I: begin
          r_si <= ksa.mem_rdata;
          r_j  <= r_j + ksa.mem_rdata + w_kb;
        end
        S_LD_J: r_sj <= ksa.mem_rdata;
        S_WR_J: begin
          r_i    <= r_i + DATA_W'(1);
          r_kidx <= (r_kidx == r_kmax) ? '0 : r_kidx + KIDX_W'(1);
        end
        default: r_i <= r_i;
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb/tb_rc4_ksa_engine.sv - directed bench for rc4_ksa_engine with behavioural 1-cycle sync RAMs
// Keyed-length scenario is built only when RC4_KSA_KEYLEN_EN is defined.
module tb_rc4_ksa_engine;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_s[256];
  int hold_s[256];

  rc4_ksa_engine_if #(.DATA_W(2), .KEY_BYTES(1)) bus_a ();
  rc4_ksa_engine #(.DATA_W(2), .KEY_BYTES(1)) dut_a (.i_clk(clk), .i_reset_n(reset_n), .ksa(bus_a));
  rc4_ksa_engine_if #(.DATA_W(8), .KEY_BYTES(3)) bus_b ();
  rc4_ksa_engine #(.DATA_W(8), .KEY_BYTES(3)) dut_b (.i_clk(clk), .i_reset_n(reset_n), .ksa(bus_b));

  logic [1:0] mem_a[4];
  logic [7:0] mem_b[256];

  always @(posedge clk) begin
    if (bus_a.mem_wren) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    if (bus_b.mem_wren) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
  end

`ifdef RC4_KSA_KEYLEN_EN
  rc4_ksa_engine_if #(.DATA_W(2), .KEY_BYTES(3)) bus_c ();
  rc4_ksa_engine #(.DATA_W(2), .KEY_BYTES(3)) dut_c (.i_clk(clk), .i_reset_n(reset_n), .ksa(bus_c));
  logic [1:0] mem_c[4];
  always @(posedge clk) begin
    if (bus_c.mem_wren) mem_c[bus_c.mem_addr] <= bus_c.mem_wdata;
    bus_c.mem_rdata <= mem_c[bus_c.mem_addr];
  end
`endif

  // Reference software RC4 KSA; key bytes truncated to the S-box width
  task automatic ksa_model(input logic [23:0] key, input int nb, input int l, input int n);
    int j, t, kb;
    j = 0;
    for (int i = 0; i < n; i++) exp_s[i] = i;
    for (int i = 0; i < n; i++) begin
      kb = int'((key >> (8 * (nb - 1 - (i % l)))) & 24'hFF) % n;
      j = (j + exp_s[i] + kb) % n;
      t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
    end
  endtask

  // Cycle c is sampled at the negedge before edge k+c, so done first seen at c == 7N+1
  task automatic run_a(input logic [7:0] key, output int done_cyc, output int wr_cnt,
                       output logic busy1, output bit saw_x);
    done_cyc = 0; wr_cnt = 0; busy1 = 1'b0; saw_x = 1'b0;
    bus_a.key = key;
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = bus_a.busy;
      if ($isunknown({bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_wren, bus_a.busy, bus_a.done})) saw_x = 1'b1;
      if (bus_a.mem_wren === 1'b1) wr_cnt++;
      if (bus_a.done === 1'b1) begin done_cyc = c; break; end
    end
  endtask

  task automatic run_b(input logic [23:0] key, input int repulse_at, output int done_cyc,
                       output int wr_cnt, output logic busy1);
    done_cyc = 0; wr_cnt = 0; busy1 = 1'b0;
    bus_b.key = key;
    @(negedge clk); bus_b.start = 1'b1;
    @(posedge clk); #1 bus_b.start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      bus_b.start = (c == repulse_at);
      if (c == 1) busy1 = bus_b.busy;
      if (bus_b.mem_wren === 1'b1) wr_cnt++;
      if (bus_b.done === 1'b1) begin done_cyc = c; break; end
    end
    bus_b.start = 1'b0;
  endtask

  task automatic check_a_s(input string name);
    int e[4];
    e = '{0, 2, 3, 1};
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem_a[k] !== 2'(e[k])) begin
        n_bad++; $display("FAIL %s S[%0d]: got %0d expected %0d", name, k, mem_a[k], e[k]);
      end
    end
  endtask

  task automatic check_b_s(input string name);
    for (int k = 0; k < 256; k++) begin
      n_cmp++;
      if (mem_b[k] !== 8'(exp_s[k])) begin
        n_bad++; $display("FAIL %s S[%0d]: got %0d expected %0d", name, k, mem_b[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_a.start = 1'b0; bus_a.key = '0;
    bus_b.start = 1'b0; bus_b.key = '0;
`ifdef RC4_KSA_KEYLEN_EN
    bus_a.key_len = '0; bus_b.key_len = '0;
    bus_c.start = 1'b0; bus_c.key = '0; bus_c.key_len = '0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_a.busy, bus_a.done, bus_a.mem_wren} !== 3'b000) begin
      n_bad++; $display("FAIL reset_a_ctl: got %b expected 000", {bus_a.busy, bus_a.done, bus_a.mem_wren});
    end
    n_cmp++;
    if ({bus_a.mem_addr, bus_a.mem_wdata} !== 4'h0) begin
      n_bad++; $display("FAIL reset_a_mem: got %h expected 0", {bus_a.mem_addr, bus_a.mem_wdata});
    end
    n_cmp++;
    if ({bus_b.busy, bus_b.done, bus_b.mem_wren, bus_b.mem_addr, bus_b.mem_wdata} !== 19'd0) begin
      n_bad++; $display("FAIL reset_b_all: got %h expected 0",
                        {bus_b.busy, bus_b.done, bus_b.mem_wren, bus_b.mem_addr, bus_b.mem_wdata});
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_start: busy got %b expected 0", bus_a.busy); end
  endtask

  task automatic test_key01();
    int dc, wc; logic b1; bit sx;
    run_a(8'h01, dc, wc, b1, sx);
    n_cmp++; if (dc !== 29) begin n_bad++; $display("FAIL key01_done_cycle: got %0d expected 29", dc); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL key01_busy_first: got %b expected 1", b1); end
    n_cmp++; if (wc !== 12) begin n_bad++; $display("FAIL key01_write_count: got %0d expected 12", wc); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL key01_busy_in_done: got %b expected 0", bus_a.busy); end
    check_a_s("key01");
  endtask

  task automatic test_self_swap();
    int dc, wc; logic b1; bit sx;
    for (int k = 0; k < 4; k++) mem_a[k] = 2'(3 - k);
    run_a(8'h00, dc, wc, b1, sx);
    n_cmp++; if (sx !== 1'b0) begin n_bad++; $display("FAIL selfswap_no_x: got %b expected 0", sx); end
    n_cmp++; if (dc !== 29) begin n_bad++; $display("FAIL selfswap_done_cycle: got %0d expected 29", dc); end
    check_a_s("selfswap");
  endtask

  task automatic test_start_at_done();
    int dc;
    dc = 0;
    bus_a.key = 8'h01;
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    for (int c = 1; c <= 100 && bus_a.done !== 1'b1; c++) @(negedge clk);
    n_cmp++; if (bus_a.done !== 1'b1) begin n_bad++; $display("FAIL sad_first_done: got %b expected 1", bus_a.done); end
    bus_a.key = 8'h00;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL sad_ignored_in_done: busy got %b expected 0", bus_a.busy); end
    @(posedge clk); #1 bus_a.start = 1'b0;
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL sad_accepted_in_idle: busy got %b expected 1", bus_a.busy); end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) begin dc = c; break; end
    end
    n_cmp++; if (dc !== 29) begin n_bad++; $display("FAIL sad_done_cycle: got %0d expected 29", dc); end
    check_a_s("start_at_done");
  endtask

  task automatic test_full_key();
    int dc, wc; logic b1;
    ksa_model(24'h000249, 3, 3, 256);
    run_b(24'h000249, 0, dc, wc, b1);
    n_cmp++; if (dc !== 1793) begin n_bad++; $display("FAIL full_done_cycle: got %0d expected 1793", dc); end
    n_cmp++; if (wc !== 768) begin n_bad++; $display("FAIL full_write_count: got %0d expected 768", wc); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL full_busy_first: got %b expected 1", b1); end
    check_b_s("full_key");
  endtask

  task automatic test_interference();
    int dc, wc; logic b1;
    for (int k = 0; k < 256; k++) mem_b[k] = 8'hEE;
    ksa_model(24'h000249, 3, 3, 256);
    run_b(24'h000249, 500, dc, wc, b1);
    n_cmp++; if (dc !== 1793) begin n_bad++; $display("FAIL repulse_done_cycle: got %0d expected 1793", dc); end
    check_b_s("repulse");

    bus_b.key = 24'h000249;
    @(negedge clk); bus_b.start = 1'b1;
    @(posedge clk); #1 bus_b.start = 1'b0;
    repeat (900) @(negedge clk);
    n_cmp++; if (bus_b.busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b expected 1", bus_b.busy); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_b.busy, bus_b.done, bus_b.mem_wren, bus_b.mem_addr, bus_b.mem_wdata} !== 19'd0) begin
      n_bad++; $display("FAIL async_reset_outputs: got %h expected 0",
                        {bus_b.busy, bus_b.done, bus_b.mem_wren, bus_b.mem_addr, bus_b.mem_wdata});
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus_b.busy !== 1'b0) begin n_bad++; $display("FAIL reset_to_idle: busy got %b expected 0", bus_b.busy); end

    ksa_model(24'h1A2B3C, 3, 3, 256);
    run_b(24'h1A2B3C, 0, dc, wc, b1);
    n_cmp++; if (dc !== 1793) begin n_bad++; $display("FAIL after_reset_done_cycle: got %0d expected 1793", dc); end
    check_b_s("after_reset");
  endtask

`ifdef RC4_KSA_KEYLEN_EN
  task automatic run_c(input logic [23:0] key, input logic [1:0] klen, output int done_cyc);
    done_cyc = 0;
    bus_c.key = key; bus_c.key_len = klen;
    @(negedge clk); bus_c.start = 1'b1;
    @(posedge clk); #1 bus_c.start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus_c.done === 1'b1) begin done_cyc = c; break; end
    end
  endtask

  task automatic test_keylen();
    int dc;
    int e[4];
    e = '{0, 2, 3, 1};
    run_c(24'h01ABCD, 2'd1, dc);
    n_cmp++; if (dc !== 29) begin n_bad++; $display("FAIL keylen1_done_cycle: got %0d expected 29", dc); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem_c[k] !== 2'(e[k])) begin n_bad++; $display("FAIL keylen1 S[%0d]: got %0d expected %0d", k, mem_c[k], e[k]); end
    end
    ksa_model(24'h01ABCD, 3, 3, 4);
    run_c(24'h01ABCD, 2'd3, dc);
    for (int k = 0; k < 4; k++) begin
      hold_s[k] = int'(mem_c[k]);
      n_cmp++;
      if (mem_c[k] !== 2'(exp_s[k])) begin n_bad++; $display("FAIL keylen3 S[%0d]: got %0d expected %0d", k, mem_c[k], exp_s[k]); end
    end
    run_c(24'h01ABCD, 2'd0, dc);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem_c[k] !== 2'(exp_s[k])) begin n_bad++; $display("FAIL keylen0 S[%0d]: got %0d expected %0d (len3 run %0d)", k, mem_c[k], exp_s[k], hold_s[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_key01();
    test_self_swap();
    test_start_at_done();
    test_full_key();
    test_interference();
`ifdef RC4_KSA_KEYLEN_EN
    test_keylen();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
